// File: rtl/mem_port_arbiter_if.sv
// Shared SRAM-like port bundle: inst side, data side and downstream side.
// slave = the arbiter view, master = the environment driving it.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic        err_unexp;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size,
    input  data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, rdata,
    output m_req, m_wr, m_size, m_wstrb,
    output m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output err_unexp
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size,
    output data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, rdata,
    input  m_req, m_wr, m_size, m_wstrb,
    input  m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  err_unexp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and memory stages,
// tracking issue order in an owner FIFO to route in-order responses.
module mem_port_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_nx;
  logic                   sel, sel_nx;
  logic                   owner;
  logic [OUTSTANDING-1:0] own_q;
  logic [PW-1:0]          wp, rp;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          starve, starve_nx;
  logic                   err;
  logic                   full, empty;
  logic                   push, pop, head;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = own_q[rp];

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    owner     = sel;
    bus.m_req = 1'b0;
    unique case (state)
      IDLE: begin
        if (!full && (bus.inst_req || bus.data_req)) begin
          owner = bus.data_req &&
                  !(bus.inst_req && starve == SLIM);
          sel_nx    = owner;
          bus.m_req = 1'b1;
          if (!bus.m_addr_ok) state_nx = HOLD;
        end
      end
      HOLD: begin
        bus.m_req = 1'b1;
        if (bus.m_addr_ok) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // inst side is always a word read with no write data
  assign bus.m_wr    = owner & bus.data_wr;
  assign bus.m_size  = owner ? bus.data_size  : 2'd2;
  assign bus.m_wstrb = owner ? bus.data_wstrb : 4'h0;
  assign bus.m_addr  = owner ? bus.data_addr  : bus.inst_addr;
  assign bus.m_wdata = owner ? bus.data_wdata : 32'h0;

  assign push = bus.m_req & bus.m_addr_ok;
  assign pop  = bus.m_data_ok & ~empty;

  assign bus.inst_addr_ok = push & ~owner;
  assign bus.data_addr_ok = push & owner;
  assign bus.inst_data_ok = pop & ~head;
  assign bus.data_data_ok = pop & head;
  assign bus.rdata        = bus.m_rdata;
  assign bus.err_unexp    = err;

  always_comb begin
    starve_nx = starve;
    if (!bus.inst_req || bus.inst_addr_ok)
      starve_nx = '0;
    else if (!(bus.m_req && !owner) && starve != SLIM)
      starve_nx = starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      own_q  <= '0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      starve <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      starve <= starve_nx;
      if (push) begin
        own_q[wp] <= owner;
        wp        <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (bus.m_data_ok && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_mem_port_arbiter;

  localparam int OUT = 4;
  localparam int LIM = 8;

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        maok;
    logic        mdok;
    logic [31:0] mrdata;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        mreq;
    logic [31:0] maddr;
    logic        mwr;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
    logic [31:0] rdata;
  } row_t;

  logic clk;
  logic reset;
  mem_port_arbiter_if b();

  mem_port_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: queue of owners in issue order
  bit mq[$];
  bit hold_v;
  bit hold_o;
  int starve;
  bit merr;
  bit m_iacc, m_dacc;

  logic        s_mreq, s_iaok, s_daok, s_idok, s_ddok, s_err;
  logic [31:0] s_maddr;

  row_t tbl[14];
  bit   ord[3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic row_t row(
    logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
    logic ma, logic md, logic [31:0] mr,
    logic er, logic [31:0] ea, logic ew,
    logic eia, logic eda, logic eid, logic edd, logic [31:0] erd);
    row_t r;
    r = '0;
    r.s.ireq = ir;   r.s.iaddr = ia;
    r.s.dreq = dr;   r.s.daddr = da;
    r.s.dwr = 1'b1;  r.s.dsize = 2'd2;
    r.s.dwstrb = 4'hf; r.s.dwdata = 32'hdeadbeef;
    r.s.maok = ma;   r.s.mdok = md;  r.s.mrdata = mr;
    r.mreq = er; r.maddr = ea; r.mwr = ew;
    r.iaok = eia; r.daok = eda; r.idok = eid; r.ddok = edd;
    r.rdata = erd;
    return r;
  endfunction

  function automatic stim_t si(logic [31:0] a, logic ma, logic md);
    stim_t s;
    s = '0;
    s.ireq = 1'b1; s.iaddr = a;
    s.maok = ma;   s.mdok = md; s.mrdata = $urandom;
    return s;
  endfunction

  function automatic stim_t sd(logic [31:0] a, logic wr,
                               logic ma, logic md);
    stim_t s;
    s = '0;
    s.dreq = 1'b1; s.daddr = a; s.dwr = wr;
    s.dsize = 2'd2; s.dwstrb = wr ? 4'hf : 4'h0;
    s.dwdata = $urandom;
    s.maok = ma; s.mdok = md; s.mrdata = $urandom;
    return s;
  endfunction

  function automatic stim_t sn(logic md);
    stim_t s;
    s = '0;
    s.mdok = md; s.mrdata = $urandom;
    return s;
  endfunction

  task automatic run(input stim_t s, input bit use_row,
                     input row_t r);
    bit pres, own, acc, pp, hd, emp;
    reset          = s.rst;
    b.inst_req     = s.ireq;
    b.inst_addr    = s.iaddr;
    b.data_req     = s.dreq;
    b.data_wr      = s.dwr;
    b.data_size    = s.dsize;
    b.data_wstrb   = s.dwstrb;
    b.data_addr    = s.daddr;
    b.data_wdata   = s.dwdata;
    b.m_addr_ok    = s.maok;
    b.m_data_ok    = s.mdok;
    b.m_rdata      = s.mrdata;
    pres = 1'b0; own = 1'b0;
    if (hold_v) begin
      pres = 1'b1; own = hold_o;
    end else if (mq.size() < OUT && (s.ireq || s.dreq)) begin
      pres = 1'b1;
      own  = s.dreq && !(s.ireq && starve == LIM);
    end
    acc = pres && s.maok;
    emp = (mq.size() == 0);
    pp  = s.mdok && !emp;
    hd  = pp ? mq[0] : 1'b0;
    #3;
    s_mreq = b.m_req;         s_maddr = b.m_addr;
    s_iaok = b.inst_addr_ok;  s_daok = b.data_addr_ok;
    s_idok = b.inst_data_ok;  s_ddok = b.data_data_ok;
    s_err  = b.err_unexp;
    if (!s.rst) begin
      chk("m_req", b.m_req, pres);
      if (pres) begin
        chk("m_addr", b.m_addr, own ? s.daddr : s.iaddr);
        chk("m_wr", b.m_wr, own & s.dwr);
        chk("m_size", b.m_size, own ? s.dsize : 2'd2);
        chk("m_wstrb", b.m_wstrb, own ? s.dwstrb : 4'h0);
        chk("m_wdata", b.m_wdata, own ? s.dwdata : 32'h0);
      end
      chk("inst_addr_ok", b.inst_addr_ok, acc && !own);
      chk("data_addr_ok", b.data_addr_ok, acc && own);
      chk("inst_data_ok", b.inst_data_ok, pp && !hd);
      chk("data_data_ok", b.data_data_ok, pp && hd);
      if (pp) chk("rdata", b.rdata, s.mrdata);
      chk("err_unexp", b.err_unexp, merr);
      if (use_row) begin
        chk("tbl_m_req", b.m_req, r.mreq);
        if (r.mreq) begin
          chk("tbl_m_addr", b.m_addr, r.maddr);
          chk("tbl_m_wr", b.m_wr, r.mwr);
        end
        chk("tbl_inst_addr_ok", b.inst_addr_ok, r.iaok);
        chk("tbl_data_addr_ok", b.data_addr_ok, r.daok);
        chk("tbl_inst_data_ok", b.inst_data_ok, r.idok);
        chk("tbl_data_data_ok", b.data_data_ok, r.ddok);
        if (r.idok || r.ddok) chk("tbl_rdata", b.rdata, r.rdata);
      end
    end
    m_iacc = !s.rst && acc && !own;
    m_dacc = !s.rst && acc && own;
    @(posedge clk);
    if (s.rst) begin
      mq.delete();
      hold_v = 1'b0; hold_o = 1'b0; starve = 0; merr = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(own);
      hold_v = pres && !acc;
      hold_o = own;
      if (!s.ireq || (acc && !own)) starve = 0;
      else if (!(pres && !own) && starve < LIM) starve++;
      if (s.mdok && emp) merr = 1'b1;
    end
    #1;
  endtask

  task automatic cyc(input stim_t s);
    row_t r;
    r = '0;
    run(s, 1'b0, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && mq.size() > 0; i++) cyc(sn(1'b1));
    chk("drain_empty", mq.size(), 0);
  endtask

  initial begin
    stim_t s;
    int    grant_k;
    bit    r_ireq, r_dreq, r_dwr;
    logic [31:0] r_iaddr, r_daddr, r_dwdata;
    logic [1:0]  r_dsize;
    logic [3:0]  r_dwstrb;

    hold_v = 0; hold_o = 0; starve = 0; merr = 0;
    @(posedge clk);
    #1;
    s = '0;
    s.rst = 1'b1;
    cyc(s);
    cyc(s);

    cyc(sn(1'b0));
    chk("rst_m_req", s_mreq, 0);
    chk("rst_iaok", s_iaok, 0);
    chk("rst_daok", s_daok, 0);
    chk("rst_err", s_err, 0);

    // lone fetch, contention, hold
    tbl[0]  = row(1, 32'h1c000000, 0, 0, 1, 0, 0,
                  1, 32'h1c000000, 0, 1, 0, 0, 0, 0);
    tbl[1]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = row(0, 0, 0, 0, 0, 1, 32'h02800c0c,
                  0, 0, 0, 0, 0, 1, 0, 32'h02800c0c);
    tbl[3]  = row(1, 32'h1c000004, 1, 32'h1c0100f0, 1, 0, 0,
                  1, 32'h1c0100f0, 1, 0, 1, 0, 0, 0);
    tbl[4]  = row(1, 32'h1c000004, 0, 0, 1, 0, 0,
                  1, 32'h1c000004, 0, 1, 0, 0, 0, 0);
    tbl[5]  = row(0, 0, 0, 0, 0, 1, 32'ha5a5a5a5,
                  0, 0, 0, 0, 0, 0, 1, 32'ha5a5a5a5);
    tbl[6]  = row(0, 0, 0, 0, 0, 1, 32'h11111111,
                  0, 0, 0, 0, 0, 1, 0, 32'h11111111);
    tbl[7]  = row(1, 32'h1c000008, 1, 32'h1c0100f0, 0, 0, 0,
                  1, 32'h1c0100f0, 1, 0, 0, 0, 0, 0);
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = row(1, 32'h1c000008, 1, 32'h1c0100f0, 1, 0, 0,
                  1, 32'h1c0100f0, 1, 0, 1, 0, 0, 0);
    tbl[11] = row(1, 32'h1c000008, 0, 0, 1, 0, 0,
                  1, 32'h1c000008, 0, 1, 0, 0, 0, 0);
    tbl[12] = row(0, 0, 0, 0, 0, 1, 32'h22222222,
                  0, 0, 0, 0, 0, 0, 1, 32'h22222222);
    tbl[13] = row(0, 0, 0, 0, 0, 1, 32'h33333333,
                  0, 0, 0, 0, 0, 1, 0, 32'h33333333);
    for (int i = 0; i < 14; i++) run(tbl[i].s, 1'b1, tbl[i]);

    // ordering and full FIFO
    cyc(si(32'h100, 1, 0));
    cyc(sd(32'h200, 0, 1, 0));
    cyc(si(32'h104, 1, 0));
    cyc(sd(32'h204, 1, 1, 0));
    cyc(si(32'h108, 1, 0));
    chk("full_no_mreq", s_mreq, 0);
    chk("full_no_iaok", s_iaok, 0);
    cyc(si(32'h108, 1, 1));
    chk("full_pop_mreq", s_mreq, 0);
    chk("pop0_inst", s_idok, 1);
    cyc(si(32'h108, 1, 1));
    chk("pushpop_iaok", s_iaok, 1);
    chk("pop1_data", s_ddok, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(sn(1'b1));
      chk("order_idok", s_idok, !ord[i]);
      chk("order_ddok", s_ddok, ord[i]);
    end
    chk("order_empty", mq.size(), 0);

    // starvation
    grant_k = -1;
    for (int k = 0; k < 20 && grant_k < 0; k++) begin
      s = sd(32'h300 + 32'(k * 4), 1, 1, mq.size() > 0);
      s.ireq = 1'b1;
      s.iaddr = 32'h400;
      cyc(s);
      if (s_iaok) grant_k = k;
    end
    chk("starve_grant_cycle", grant_k, 8);
    s = sd(32'h380, 1, 1, mq.size() > 0);
    s.ireq = 1'b1;
    s.iaddr = 32'h404;
    cyc(s);
    chk("starve_clear_daok", s_daok, 1);
    chk("starve_clear_iaok", s_iaok, 0);
    drain();

    // unexpected response, reset in HOLD
    cyc(sn(1'b1));
    chk("unexp_idok", s_idok, 0);
    chk("unexp_ddok", s_ddok, 0);
    cyc(sn(1'b0));
    chk("unexp_err", s_err, 1);
    cyc(sd(32'h500, 1, 0, 0));
    chk("hold_mreq", s_mreq, 1);
    s = sd(32'h500, 1, 0, 0);
    s.rst = 1'b1;
    cyc(s);
    cyc(sn(1'b0));
    chk("post_rst_mreq", s_mreq, 0);
    chk("post_rst_err", s_err, 0);
    cyc(sn(1'b1));
    chk("post_rst_no_ddok", s_ddok, 0);
    chk("post_rst_no_idok", s_idok, 0);
    cyc(sn(1'b0));
    chk("post_rst_empty", s_err, 1);
    s = '0;
    s.rst = 1'b1;
    cyc(s);

    // random traffic
    r_ireq = 0; r_dreq = 0; r_dwr = 0;
    r_iaddr = 0; r_daddr = 0; r_dwdata = 0;
    r_dsize = 0; r_dwstrb = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!r_ireq && $urandom_range(1, 0) == 1) begin
        r_ireq = 1;
        r_iaddr = $urandom & 32'hfffffffc;
      end
      if (!r_dreq && $urandom_range(1, 0) == 1) begin
        r_dreq = 1;
        r_dwr = $urandom_range(1, 0) == 1;
        r_dsize = 2'($urandom_range(2, 0));
        r_dwstrb = 4'($urandom);
        r_daddr = $urandom;
        r_dwdata = $urandom;
      end
      s = '0;
      s.ireq = r_ireq;   s.iaddr = r_iaddr;
      s.dreq = r_dreq;   s.dwr = r_dwr;
      s.dsize = r_dsize; s.dwstrb = r_dwstrb;
      s.daddr = r_daddr; s.dwdata = r_dwdata;
      s.maok = $urandom_range(2, 0) != 0;
      s.mdok = mq.size() > 0 && $urandom_range(1, 0) == 1;
      s.mrdata = $urandom;
      cyc(s);
      if (m_iacc) r_ireq = 0;
      if (m_dacc) r_dreq = 0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
